t_ff: RTL and testbench

- Parameterisable bank of toggle (T) flip-flops. Each bit inverts its stored state on a rising clock edge when its T input is high, and holds otherwise.
- Used as a generic toggle/divide-by-2 primitive in control and counter logic.
- Default configuration is a single-bit T flip-flop with output q.

---
 rtl/t_ff_pkg.sv | 9 +
 rtl/t_ff_bit.sv | 40 ++++
 rtl/t_ff.sv | 38 +++
 tb/tb_t_ff.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/t_ff_pkg.sv
// t_ff_pkg: shared constants for the toggle flip-flop bank.
//   T_FF_DEF_WIDTH  default number of bits in a bank
//   T_FF_RST_BIT    default per-bit reset/clear value
package t_ff_pkg;

  localparam int   T_FF_DEF_WIDTH = 1;
  localparam logic T_FF_RST_BIT   = 1'b0;

endpackage

// File: rtl/t_ff_bit.sv
// t_ff_bit: single-bit T flip-flop with async reset, sync clear and enable.
//   clk, rst   clock, async active-high reset
//   en         hold when low
//   sclr       sync clear to RESET_VALUE, beats toggling and en
//   t          toggle request, sampled on the rising edge
//   q          stored state
//   toggled    high for one cycle after q toggled
module t_ff_bit
  import t_ff_pkg::*;
#(
  parameter logic RESET_VALUE = T_FF_RST_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sclr,
  input  logic t,
  output logic q,
  output logic toggled
);

  // sclr and !en are tested before t, so an unknown t never reaches q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= RESET_VALUE;
      toggled <= 1'b0;
    end else if (sclr) begin
      q       <= RESET_VALUE;
      toggled <= 1'b0;
    end else if (!en) begin
      toggled <= 1'b0;
    end else if (t) begin
      q       <= ~q;
      toggled <= 1'b1;
    end else begin
      toggled <= 1'b0;
    end
  end

endmodule

// File: rtl/t_ff.sv
// t_ff: bank of WIDTH independent T flip-flops.
//   clk, rst   clock, async active-high reset (q <= RESET_VALUE)
//   en         global enable; all bits hold when low
//   sclr       sync clear to RESET_VALUE, priority over toggling
//   t          per-bit toggle request
//   q, q_n     stored state and its combinational inverse
//   toggled    per-bit one-cycle flag after that bit toggled
module t_ff
  import t_ff_pkg::*;
#(
  parameter int               WIDTH       = T_FF_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] toggled
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_bit #(.RESET_VALUE(RESET_VALUE[i])) u_bit (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .sclr    (sclr),
      .t       (t[i]),
      .q       (q[i]),
      .toggled (toggled[i])
    );
  end

  assign q_n = ~q;

endmodule

// File: tb/tb_t_ff.sv
// tb_t_ff: checks a default 1-bit bank with hand-written sequences and a
// 4-bit bank (RESET_VALUE = 4'b1010) with a vector table plus random
// stimulus against a reference model.
module tb_t_ff;

  localparam logic [3:0] RV4 = 4'b1010;

  logic       clk;
  logic       rst1, en1, sclr1;
  logic [0:0] t1, q1, qn1, tg1;
  logic       rst4, en4, sclr4;
  logic [3:0] t4, q4, qn4, tg4;

  int total = 0;
  int bad   = 0;

  t_ff dut1 (
    .clk(clk), .rst(rst1), .en(en1), .sclr(sclr1), .t(t1),
    .q(q1), .q_n(qn1), .toggled(tg1)
  );

  t_ff #(.WIDTH(4), .RESET_VALUE(RV4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .sclr(sclr4), .t(t4),
    .q(q4), .q_n(qn4), .toggled(tg4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%b exp=%b @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic eq, input logic etg);
    chk({name, ".q"},   {3'b0, q1},  {3'b0, eq});
    chk({name, ".q_n"}, {3'b0, qn1}, {3'b0, ~eq});
    chk({name, ".tog"}, {3'b0, tg1}, {3'b0, etg});
  endtask

  typedef struct {
    logic       rst, sclr, en;
    logic [3:0] t;
    logic [3:0] eq, etg;
  } vec_t;

  vec_t vecs[10];
  logic [3:0] mq, mt;
  logic       m1;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b1010, 4'b0000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 4'b0110, 4'b1100, 4'b0110};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1100, 4'b0000};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b1100, 4'b0000};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 4'b1111, 4'b0011, 4'b1111};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 4'b1111, 4'b1010, 4'b0000};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 4'b1111, 4'b1010, 4'b0000};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 4'b0001, 4'b1011, 4'b0001};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 4'b1000, 4'b0011, 4'b1000};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b1010, 4'b0000};

    rst1 = 1'b1; en1 = 1'b1; sclr1 = 1'b0; t1 = 1'b0;
    rst4 = 1'b1; en4 = 1'b1; sclr4 = 1'b0; t4 = 4'b0;

    // reset held across the first edge
    #1  chk1("rst_t1", 1'b0, 1'b0);
    #5  chk1("rst_t6", 1'b0, 1'b0);
    #8  chk1("rst_t14", 1'b0, 1'b0);
    #2  rst1 = 1'b0;

    // hold
    repeat (2) @(posedge clk);
    #1 chk1("hold", 1'b0, 1'b0);

    // single toggle, then flag drops
    @(negedge clk) t1 = 1'b1;
    @(posedge clk) #1 chk1("tog1", 1'b1, 1'b1);
    @(negedge clk) t1 = 1'b0;
    @(posedge clk) #1 chk1("tog1_after", 1'b1, 1'b0);

    // async reset mid-cycle with q = 1
    @(negedge clk) #1 rst1 = 1'b1;
    #1 chk1("async_rst", 1'b0, 1'b0);
    #1 rst1 = 1'b0;

    // three consecutive toggles: 1, 0, 1
    @(negedge clk) t1 = 1'b1;
    m1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m1 = ~m1;
      @(posedge clk) #1 chk1($sformatf("sq%0d", i), m1, 1'b1);
    end
    @(negedge clk) t1 = 1'b0;
    @(posedge clk) #1;

    // 5 ns pulses straddling each edge: five toggles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) #2 t1 = 1'b1;
      #5 t1 = 1'b0;
      m1 = ~m1;
    end
    chk1("pulse_on", m1, 1'b1);

    // pulses placed between edges: no effect
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) #7 t1 = 1'b1;
      #5 t1 = 1'b0;
    end
    #1 chk1("pulse_off", m1, 1'b0);

    // enable low with t = 1, and with t unknown
    @(negedge clk) en1 = 1'b0; t1 = 1'b1;
    @(posedge clk) #1 chk1("en_low", m1, 1'b0);
    @(negedge clk) t1 = 1'bx;
    @(posedge clk) #1 chk1("en_low_x", m1, 1'b0);

    // get q = 1, then sclr with t = 1
    @(negedge clk) en1 = 1'b1; t1 = ~m1;
    @(posedge clk) #1 chk1("pre_sclr", 1'b1, ~m1);
    @(negedge clk) sclr1 = 1'b1; t1 = 1'bx;
    @(posedge clk) #1 chk1("sclr", 1'b0, 1'b0);
    @(negedge clk) sclr1 = 1'b0; t1 = 1'b1;
    @(posedge clk) #1 chk1("pre_rst_sclr", 1'b1, 1'b1);

    // rst and sclr together
    @(negedge clk) rst1 = 1'b1; sclr1 = 1'b1;
    #1 chk1("rst_sclr_async", 1'b0, 1'b0);
    @(posedge clk) #1 chk1("rst_sclr", 1'b0, 1'b0);
    @(negedge clk) rst1 = 1'b0; sclr1 = 1'b0; t1 = 1'b0;

    // 4-bit table
    foreach (vecs[i]) begin
      @(negedge clk);
      rst4 = vecs[i].rst; sclr4 = vecs[i].sclr; en4 = vecs[i].en; t4 = vecs[i].t;
      @(posedge clk) #1;
      chk($sformatf("vec%0d.q", i),   q4,  vecs[i].eq);
      chk($sformatf("vec%0d.q_n", i), qn4, ~vecs[i].eq);
      chk($sformatf("vec%0d.tog", i), tg4, vecs[i].etg);
    end

    // random against the model
    @(negedge clk) rst4 = 1'b1; sclr4 = 1'b0; en4 = 1'b1; t4 = 4'b0;
    mq = RV4; mt = 4'b0;
    @(posedge clk) #1 chk("rnd_init", q4, mq);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst4  = ($urandom_range(0, 99) < 3);
      sclr4 = ($urandom_range(0, 99) < 8);
      en4   = ($urandom_range(0, 99) < 80);
      t4    = 4'($urandom);
      if (rst4 || sclr4) begin
        mq = RV4; mt = 4'b0;
      end else if (!en4) begin
        mt = 4'b0;
      end else begin
        mq = mq ^ t4; mt = t4;
      end
      @(posedge clk) #1;
      chk($sformatf("rnd%0d.q", i),   q4,  mq);
      chk($sformatf("rnd%0d.q_n", i), qn4, ~mq);
      chk($sformatf("rnd%0d.tog", i), tg4, mt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
